// File: rtl/sobel_pkg.sv
// Shared constants and types for the serial Sobel window engine.
package sobel_pkg;

  localparam int unsigned PixWDef = 8;
  localparam int unsigned AccWDef = 12;
  localparam int unsigned NumTaps = 9;

  typedef enum logic [0:0] {StAcc, StOut} state_e;

  typedef logic [1:0] idx_t;

endpackage

// File: rtl/sobel_window_mac_kernel.sv
// Combinational Sobel coefficient table: row selects Xindex_i, column selects Yindex_i.
// Coefficients are 3-bit two's complement in the range -2..2.
module Sobel_Kernel (
  input  logic [1:0] Xindex_i,
  input  logic [1:0] Yindex_i,
  output logic [2:0] coef_x_o,
  output logic [2:0] coef_y_o
);

  logic [2:0] wx;
  logic [2:0] wy;

  // Centre row/column carries weight 2, outer ones weight 1.
  assign wx = (Xindex_i == 2'd1) ? 3'd2 : 3'd1;
  assign wy = (Yindex_i == 2'd1) ? 3'd2 : 3'd1;

  always_comb begin
    coef_x_o = 3'd0;
    coef_y_o = 3'd0;
    if (Xindex_i != 2'd3 && Yindex_i != 2'd3) begin
      if (Yindex_i == 2'd0) begin
        coef_x_o = -wx;
      end else if (Yindex_i == 2'd2) begin
        coef_x_o = wx;
      end
      if (Xindex_i == 2'd0) begin
        coef_y_o = wy;
      end else if (Xindex_i == 2'd2) begin
        coef_y_o = -wy;
      end
    end
  end

endmodule

// File: rtl/sobel_window_mac.sv
// Serial 3x3 Sobel MAC: accumulates Gx/Gy over 9 raster-order taps, emits |Gx|+|Gy|.
// Define SOBEL_THRESHOLD_EN to binarize pix_o against THRESHOLD instead of saturating.
module sobel_window_mac
  import sobel_pkg::*;
#(
  parameter int unsigned PIX_W     = PixWDef,
  parameter int unsigned ACC_W     = AccWDef,
  parameter int unsigned THRESHOLD = 128
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [PIX_W-1:0]   pix_i,
  input  logic               pix_first_i,
  input  logic               pix_valid_i,
  output logic               pix_ready_o,
  output logic [ACC_W-1:0]   gx_o,
  output logic [ACC_W-1:0]   gy_o,
  output logic [ACC_W-2:0]   mag_o,
  output logic [PIX_W-1:0]   pix_o,
  output logic               out_valid_o,
  input  logic               out_ready_i
);

  state_e state_q, state_d;
  idx_t   row_q, row_d, col_q, col_d;
  idx_t   tap_row, tap_col;

  logic signed [ACC_W-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic signed [ACC_W-1:0] base_x, base_y, sum_x, sum_y, prod_x, prod_y, pix_ext;
  logic        [ACC_W-1:0] abs_x, abs_y;
  logic        [ACC_W-2:0] mag_next;
  logic        [PIX_W-1:0] pix_next;
  logic [2:0] coef_x, coef_y;
  logic       accept, last_tap, load_out;

  assign pix_ready_o = (state_q == StAcc);
  assign out_valid_o = (state_q == StOut);
  assign accept      = pix_valid_i & pix_ready_o;

  // A first-flagged pixel restarts the window at tap 0 regardless of the counters.
  assign tap_row  = pix_first_i ? '0 : row_q;
  assign tap_col  = pix_first_i ? '0 : col_q;
  assign last_tap = (4'(tap_row) * 4'd3 + 4'(tap_col)) == 4'(NumTaps - 1);

  Sobel_Kernel u_kernel (
    .Xindex_i (tap_row),
    .Yindex_i (tap_col),
    .coef_x_o (coef_x),
    .coef_y_o (coef_y)
  );

  assign pix_ext = $signed({{(ACC_W-PIX_W){1'b0}}, pix_i});
  assign prod_x  = ACC_W'($signed(coef_x)) * pix_ext;
  assign prod_y  = ACC_W'($signed(coef_y)) * pix_ext;
  assign base_x  = pix_first_i ? '0 : acc_x_q;
  assign base_y  = pix_first_i ? '0 : acc_y_q;
  assign sum_x   = base_x + prod_x;
  assign sum_y   = base_y + prod_y;

  assign abs_x    = sum_x[ACC_W-1] ? $unsigned(-sum_x) : $unsigned(sum_x);
  assign abs_y    = sum_y[ACC_W-1] ? $unsigned(-sum_y) : $unsigned(sum_y);
  assign mag_next = (ACC_W-1)'(abs_x + abs_y);

`ifdef SOBEL_THRESHOLD_EN
  assign pix_next = (mag_next >= (ACC_W-1)'(THRESHOLD)) ? '1 : '0;
`else
  logic unused_threshold;
  assign unused_threshold = ^THRESHOLD;
  assign pix_next = (|mag_next[ACC_W-2:PIX_W]) ? '1 : mag_next[PIX_W-1:0];
`endif

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    acc_x_d  = acc_x_q;
    acc_y_d  = acc_y_q;
    load_out = 1'b0;
    unique case (state_q)
      StAcc: begin
        if (accept) begin
          acc_x_d = sum_x;
          acc_y_d = sum_y;
          if (last_tap) begin
            state_d  = StOut;
            row_d    = '0;
            col_d    = '0;
            load_out = 1'b1;
          end else if (tap_col == 2'd2) begin
            row_d = tap_row + 2'd1;
            col_d = '0;
          end else begin
            row_d = tap_row;
            col_d = tap_col + 2'd1;
          end
        end
      end
      StOut: begin
        if (out_ready_i) begin
          state_d = StAcc;
          acc_x_d = '0;
          acc_y_d = '0;
        end
      end
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StAcc;
      row_q   <= '0;
      col_q   <= '0;
      acc_x_q <= '0;
      acc_y_q <= '0;
      gx_o    <= '0;
      gy_o    <= '0;
      mag_o   <= '0;
      pix_o   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      acc_x_q <= acc_x_d;
      acc_y_q <= acc_y_d;
      if (load_out) begin
        gx_o  <= sum_x;
        gy_o  <= sum_y;
        mag_o <= mag_next;
        pix_o <= pix_next;
      end
    end
  end

endmodule
